// File: rtl/bus_arbiter_rr_if.sv
// rtl/bus_arbiter_rr_if.sv - requester/arbiter bundle for the shared decoder address bus
interface bus_arbiter_rr_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 4
);
  logic [NREQ-1:0]        req;
  logic [NREQ*ADDR_W-1:0] addr_in;
  logic [NREQ-1:0]        done;
  logic [NREQ-1:0]        gnt;
  logic [ADDR_W-1:0]      bus_addr;
  logic                   bus_valid;
  logic                   busy;
  logic                   timeout_err;

  // master: the requester side; slave: the arbiter
  modport master (
    output req, addr_in, done,
    input  gnt, bus_addr, bus_valid, busy, timeout_err
  );

  modport slave (
    input  req, addr_in, done,
    output gnt, bus_addr, bus_valid, busy, timeout_err
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin owner arbiter for the decoder address bus
// Optional ownership watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 4,
  parameter int TMO_CYC = 15
) (
  input logic             clk,
  input logic             rst,
  bus_arbiter_rr_if.slave bus
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  if (NREQ != 4 || TMO_CYC < 1) begin : g_bad_cfg
    $error("bus_arbiter_rr: NREQ must be 4 and TMO_CYC at least 1");
  end

  logic [1:0]        state;
  logic [1:0]        own;
  logic [1:0]        ptr;
  logic [NREQ-1:0]   gnt_q;
  logic              pick_found;
  logic [1:0]        pick_idx;
  logic              normal_rel;
  logic              expire;
  logic [ADDR_W-1:0] addr_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign addr_arr[i] = bus.addr_in[i*ADDR_W +: ADDR_W];
  end

  // Scan downward so the lowest offset from ptr is the one left standing.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[ptr + 2'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr + 2'(k);
      end
    end
  end

  assign normal_rel = bus.done[own] | ~bus.req[own];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] wd_cnt;
  logic          terr_q;

  // Held at zero outside GRANT, so every new ownership starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state != S_GRANT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign expire = (state == S_GRANT) && (wd_cnt == CW'(TMO_CYC - 1));

  // A genuine release on the expiry cycle wins, so no error is flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      terr_q <= 1'b0;
    end else begin
      terr_q <= expire & ~normal_rel;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign expire          = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      own   <= '0;
      ptr   <= '0;
      gnt_q <= '0;
    end else begin
      case (state)
        S_GRANT: begin
          if (normal_rel || expire) begin
            state <= S_RELEASE;
            gnt_q <= '0;
          end
        end
        default: begin
          if (pick_found) begin
            state <= S_GRANT;
            own   <= pick_idx;
            ptr   <= pick_idx + 2'd1;
            gnt_q <= NREQ'(1) << pick_idx;
          end else begin
            state <= S_IDLE;
            gnt_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.bus_valid = |gnt_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.bus_addr  = (state == S_GRANT) ? addr_arr[own] : '0;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - vector table, corner sequences and random model check for bus_arbiter_rr
module tb_bus_arbiter_rr;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst;

  bus_arbiter_rr_if #(.NREQ(4), .ADDR_W(4)) bif ();

  bus_arbiter_rr #(.NREQ(4), .ADDR_W(4), .TMO_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] addr;
    logic [3:0]  done;
    logic [3:0]  gnt;
    logic [3:0]  baddr;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  // reference model: owner index, phase (0 idle, 1 owned, 2 gap), rotation start
  int m_phase, m_owner, m_ptr, m_held;
  logic m_terr;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic [3:0] ea,
                           input logic eb, input logic et);
    check({tag, " gnt"}, 16'(bif.gnt), 16'(eg));
    check({tag, " bus_addr"}, 16'(bif.bus_addr), 16'(ea));
    check({tag, " bus_valid"}, 16'(bif.bus_valid), 16'(eg != 4'd0));
    check({tag, " busy"}, 16'(bif.busy), 16'(eb));
    check({tag, " timeout_err"}, 16'(bif.timeout_err), 16'(et));
  endtask

  task automatic drive(input logic r_rst, input logic [3:0] r, input logic [15:0] a, input logic [3:0] d);
    rst         = r_rst;
    bif.req     = r;
    bif.addr_in = a;
    bif.done    = d;
  endtask

  task automatic model_edge(input logic r_rst, input logic [3:0] r, input logic [3:0] d);
    m_terr = 1'b0;
    if (r_rst) begin
      m_phase = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_phase == 1) begin
      if (d[m_owner] || !r[m_owner]) m_phase = 2;
`ifdef ARB_TIMEOUT_EN
      else if (m_held == TMO) begin
        m_phase = 2;
        m_terr  = 1'b1;
      end
`endif
      else m_held++;
    end else begin
      m_phase = 0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (r[i]) begin
          m_owner = i;
          m_phase = 1;
          m_held  = 1;
          m_ptr   = (i + 1) % 4;
          break;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL time_limit: got timeout want finish");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] a;
    logic [3:0]  r, d;
    logic        rr;
    logic [3:0]  eg, ea;

    a = 16'h4321;
    drive(1'b1, 4'h0, a, 4'h0);

    // reset, single request
    vq.push_back('{1'b1, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    vq.push_back('{1'b1, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    vq.push_back('{1'b0, 4'h1, 16'h0003, 4'h0, 4'h1, 4'h3, 1'b1});
    vq.push_back('{1'b0, 4'h1, 16'h0003, 4'h1, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h0, 16'h0003, 4'h0, 4'h0, 4'h0, 1'b0});
    // fairness with all requesting
    vq.push_back('{1'b1, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    vq.push_back('{1'b0, 4'hF, a, 4'h0, 4'h1, 4'h1, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h1, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h0, 4'h2, 4'h2, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h2, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h0, 4'h4, 4'h3, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h4, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h0, 4'h8, 4'h4, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h8, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'hF, a, 4'h0, 4'h1, 4'h1, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h1, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    // rotation across gaps
    vq.push_back('{1'b1, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    vq.push_back('{1'b0, 4'hA, a, 4'h0, 4'h2, 4'h2, 1'b1});
    vq.push_back('{1'b0, 4'hA, a, 4'h2, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'hA, a, 4'h0, 4'h8, 4'h4, 1'b1});
    vq.push_back('{1'b0, 4'hA, a, 4'h8, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'hA, a, 4'h0, 4'h2, 4'h2, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h2, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    // no preemption, non-owner done ignored
    vq.push_back('{1'b0, 4'h4, a, 4'h0, 4'h4, 4'h3, 1'b1});
    vq.push_back('{1'b0, 4'h5, a, 4'h0, 4'h4, 4'h3, 1'b1});
    vq.push_back('{1'b0, 4'h5, a, 4'h1, 4'h4, 4'h3, 1'b1});
    vq.push_back('{1'b0, 4'h5, a, 4'h4, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h5, a, 4'h0, 4'h1, 4'h1, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    // request drop without done
    vq.push_back('{1'b0, 4'h2, a, 4'h0, 4'h2, 4'h2, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});
    // address change during ownership, reset mid-grant
    vq.push_back('{1'b0, 4'h4, a, 4'h0, 4'h4, 4'h3, 1'b1});
    vq.push_back('{1'b0, 4'h4, 16'h4F21, 4'h0, 4'h4, 4'hF, 1'b1});
    vq.push_back('{1'b1, 4'h4, a, 4'h0, 4'h0, 4'h0, 1'b0});
    vq.push_back('{1'b0, 4'hF, a, 4'h0, 4'h1, 4'h1, 1'b1});
    vq.push_back('{1'b0, 4'hF, 16'h432C, 4'h0, 4'h1, 4'hC, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b1});
    vq.push_back('{1'b0, 4'h0, a, 4'h0, 4'h0, 4'h0, 1'b0});

    for (int v = 0; v < vq.size(); v++) begin
      drive(vq[v].rst, vq[v].req, vq[v].addr, vq[v].done);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", v), vq[v].gnt, vq[v].baddr, vq[v].busy, 1'b0);
    end

    // long ownership: watchdog revocation, or indefinite hold without it
    drive(1'b1, 4'h0, a, 4'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 4'h3, a, 4'h0);
    for (int c = 1; c <= TMO; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("hold%0d", c), 4'h1, 4'h1, 1'b1, 1'b0);
    end
    @(posedge clk);
    #1;
`ifdef ARB_TIMEOUT_EN
    check_out("wd_expire", 4'h0, 4'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_out("wd_next_owner", 4'h2, 4'h2, 1'b1, 1'b0);
`else
    check_out("no_wd_hold", 4'h1, 4'h1, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check_out($sformatf("no_wd_hold%0d", c), 4'h1, 4'h1, 1'b1, 1'b0);
    end
`endif

    // randomized traffic against the reference model
    drive(1'b1, 4'h0, a, 4'h0);
    @(posedge clk);
    model_edge(1'b1, 4'h0, 4'h0);
    #1;
    r = 4'h0;
    for (int n = 0; n < 800; n++) begin
      rr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      d = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      a = 16'($urandom);
      drive(rr, r, a, d);
      @(posedge clk);
      model_edge(rr, r, d);
      #1;
      eg = (m_phase == 1) ? (4'h1 << m_owner) : 4'h0;
      ea = (m_phase == 1) ? 4'((a >> (4 * m_owner)) & 16'hF) : 4'h0;
      check_out($sformatf("rnd%0d", n), eg, ea, m_phase != 0, m_terr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
